// File: rtl/key_seq_pkg.sv
// Shared types and sizing helpers for the key load sequencer.
// Holds the FSM state enum, beat-count and index-width helpers.
package key_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMMIT,
        S_WIPE
    } seq_state_e;

    // Number of DW-wide beats making up one W-bit key.
    function automatic int nbeats(input int w, input int dw);
        return w / dw;
    endfunction

    // Index width for a count of n items, never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_load_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Ports: req (request vector), ptr (start index), gnt (one-hot), gnt_idx, gnt_any.
module rr_arbiter
    import key_seq_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [IW:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ and k < NREQ, so one subtraction wraps
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!gnt_any && req[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                gnt_idx          = pos[IW-1:0];
                gnt_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_load_sequencer.sv
// Arbitrates NREQ key writers onto the key register; sequences load and wipe.
// Ports: req_valid/req_data/req_last in, req_ready/req_done/req_err out,
//  soft_zeroize/tamper in, key_load/key_data/key_zeroize/grant_id/busy out.
//  With KEY_SEQ_LOCK_EN defined: lock in, locked out (sticky load lock).
module key_load_sequencer
    import key_seq_pkg::*;
#(
    parameter int W     = 128,
    parameter int DW    = 32,
    parameter int NREQ  = 3,
    parameter int ZHOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DW-1:0]     req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        req_done,
    output logic [NREQ-1:0]        req_err,
    input  logic                   soft_zeroize,
    input  logic                   tamper,
    output logic                   key_load,
    output logic [W-1:0]           key_data,
    output logic                   key_zeroize,
    output logic [idx_w(NREQ)-1:0] grant_id,
    output logic                   busy
`ifdef KEY_SEQ_LOCK_EN
    ,
    input  logic                   lock,
    output logic                   locked
`endif
);

    localparam int NBEATS = nbeats(W, DW);
    localparam int IW     = idx_w(NREQ);
    localparam int BW     = idx_w(NBEATS);
    localparam int CW     = idx_w(ZHOLD);

    seq_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   ptr_next;
    logic [NREQ-1:0] grant_oh_q;
    logic [W-1:0]    staging_q;
    logic [BW-1:0]   beat_q;
    logic [CW-1:0]   hold_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic            wipe_req;
    logic            cur_valid;
    logic            cur_last;
    logic [DW-1:0]   cur_data;
    logic            is_final;
    logic            do_grant;
    logic            do_store;
    logic            do_drop;
    logic            locked_eff;
    logic [NREQ-1:0] lock_err;

    assign wipe_req = soft_zeroize | tamper;
    assign is_final = (beat_q == BW'(NBEATS-1));
    assign ptr_next = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);
    assign busy     = (state_q != S_IDLE);
    assign key_data = key_load ? staging_q : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[DW*i +: DW];
            end
        end
    end

`ifdef KEY_SEQ_LOCK_EN
    logic            locked_q;
    logic [NREQ-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            valid_q <= req_valid;
            if (state_q == S_WIPE && state_d == S_IDLE) begin
                locked_q <= 1'b0;
            end else if (state_q == S_IDLE && lock && !wipe_req) begin
                locked_q <= 1'b1;
            end
        end
    end

    // Same-cycle lock already blocks the grant
    assign locked_eff = locked_q | lock;
    assign lock_err   = (state_q == S_IDLE && locked_eff && !wipe_req) ?
                        (req_valid & ~valid_q) : '0;
    assign locked     = locked_q;
`else
    assign locked_eff = 1'b0;
    assign lock_err   = '0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        req_done    = '0;
        req_err     = '0;
        key_load    = 1'b0;
        key_zeroize = 1'b0;
        do_grant    = 1'b0;
        do_store    = 1'b0;
        do_drop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_err = lock_err;
                if (!wipe_req && arb_any && !locked_eff) begin
                    do_grant = 1'b1;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (!wipe_req) begin
                    req_ready = grant_oh_q;
                    if (cur_valid) begin
                        if (cur_last && is_final) begin
                            do_store = 1'b1;
                            state_d  = S_COMMIT;
                        end else if (cur_last || is_final) begin
                            req_err = grant_oh_q;
                            do_drop = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            do_store = 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                if (!wipe_req) begin
                    key_load = 1'b1;
                    req_done = grant_oh_q;
                    do_drop  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_WIPE: begin
                key_zeroize = 1'b1;
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wipe_req) begin
            state_d = S_WIPE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id   <= '0;
            grant_oh_q <= '0;
            staging_q  <= '0;
            beat_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q <= state_d;
            if (wipe_req) begin
                // Every wipe request (re)starts the full hold
                hold_q    <= CW'(ZHOLD-1);
                staging_q <= '0;
                beat_q    <= '0;
            end else begin
                if (state_q == S_WIPE && hold_q != '0) begin
                    hold_q <= hold_q - CW'(1);
                end
                if (do_grant) begin
                    grant_id   <= arb_idx;
                    grant_oh_q <= arb_gnt;
                end
                if (do_store) begin
                    for (int b = 0; b < NBEATS; b++) begin
                        if (beat_q == BW'(b)) begin
                            staging_q[DW*b +: DW] <= cur_data;
                        end
                    end
                    beat_q <= beat_q + BW'(1);
                end
                if (do_drop) begin
                    staging_q <= '0;
                    beat_q    <= '0;
                    rr_ptr_q  <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_load_sequencer.sv
// Directed self-checking bench for key_load_sequencer.
// Define KEY_SEQ_LOCK_EN to also exercise the load lock.
module tb_key_load_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [95:0]  req_data;
    logic [2:0]   req_last;
    logic [2:0]   req_ready;
    logic [2:0]   req_done;
    logic [2:0]   req_err;
    logic         soft_zeroize;
    logic         tamper;
    logic         key_load;
    logic [127:0] key_data;
    logic         key_zeroize;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef KEY_SEQ_LOCK_EN
    logic         lock;
    logic         locked;
`endif

    int n_checks = 0;
    int n_errors = 0;

    key_load_sequencer #(
        .W     (128),
        .DW    (32),
        .NREQ  (3),
        .ZHOLD (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .soft_zeroize (soft_zeroize),
        .tamper       (tamper),
        .key_load     (key_load),
        .key_data     (key_data),
        .key_zeroize  (key_zeroize),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef KEY_SEQ_LOCK_EN
        ,
        .lock         (lock),
        .locked       (locked)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int r);
        logic [2:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] pat(input int r, input int k);
        return 32'hA000_0000 | 32'(r << 8) | 32'(k);
    endfunction

    task automatic clear_req();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic set_beat(input int r, input logic [31:0] d,
                            input logic l);
        clear_req();
        req_valid[r]         = 1'b1;
        req_data[32*r +: 32] = d;
        req_last[r]          = l;
    endtask

    // Grant cycle, 4 beats (d0 + step*k), then the commit cycle.
    task automatic load_key(input int r, input logic [31:0] d0,
                            input logic [31:0] step, input logic wipe,
                            input string tag);
        logic [127:0] exp;
        logic [31:0]  d;
        exp = '0;
        @(negedge clk);
        set_beat(r, d0, 1'b0);
        #1;
        check({tag, "_gnt_rdy"}, req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            d = d0 + step * 32'(k);
            exp[32*k +: 32] = d;
            @(negedge clk);
            set_beat(r, d, k == 3);
            #1;
            check({tag, "_rdy"}, req_ready, oh(r));
        end
        @(negedge clk);
        clear_req();
        soft_zeroize = wipe;
        #1;
        if (wipe) begin
            check({tag, "_load_sup"}, key_load, 0);
            check({tag, "_done_sup"}, req_done, 0);
            check({tag, "_data_sup"}, key_data, 0);
        end else begin
            check({tag, "_load"}, key_load, 1);
            check({tag, "_data"}, key_data, exp);
            check({tag, "_done"}, req_done, oh(r));
            check({tag, "_gid"}, grant_id, r);
            @(negedge clk);
            #1;
            check({tag, "_load_off"}, key_load, 0);
            check({tag, "_data_off"}, key_data, 0);
            check({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        int           cnt[3];
        int           seq[$];
        int           exp_seq[4];
        int           zc;
        int           zl;
        logic         multi;
        logic         quiet;
        logic [127:0] ek;

        rst          = 1'b1;
        soft_zeroize = 1'b0;
        tamper       = 1'b0;
        clear_req();
`ifdef KEY_SEQ_LOCK_EN
        lock = 1'b0;
`endif
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_load", key_load, 0);
        check("rst_data", key_data, 0);
        check("rst_ready", req_ready, 0);
        check("rst_zero", key_zeroize, 0);
        check("rst_gid", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single 4-beat key, little-endian assembly
        load_key(0, 32'h1111_1111, 32'h1111_1111, 1'b0, "t1");

        // 2: all requesters busy, fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt   = '{0, 0, 0};
        multi = 1'b0;
        for (int c = 0; c < 100 && seq.size() < 4; c++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                req_valid[r]         = 1'b1;
                req_data[32*r +: 32] = pat(r, cnt[r]);
                req_last[r]          = (cnt[r] == 3);
            end
            #1;
            if ($countones(req_ready) > 1) multi = 1'b1;
            for (int r = 0; r < 3; r++) begin
                if (req_ready[r]) cnt[r]++;
            end
            for (int r = 0; r < 3; r++) begin
                if (req_done[r]) begin
                    ek = {pat(r, 3), pat(r, 2), pat(r, 1), pat(r, 0)};
                    check("t2_key", key_data, ek);
                    seq.push_back(r);
                    cnt[r] = 0;
                end
            end
        end
        @(negedge clk);
        clear_req();
        check("t2_onehot", multi, 0);
        check("t2_len", seq.size(), 4);
        exp_seq = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            check("t2_order", (seq.size() > i) ? seq[i] : 99, exp_seq[i]);
        end

        // 3: short key from req1 -> error, pointer moves to req2
        @(negedge clk);
        set_beat(1, 32'hBBBB_0000, 1'b0);
        #1;
        check("t3_gnt_rdy", req_ready, 0);
        @(negedge clk);
        set_beat(1, 32'hBBBB_0000, 1'b0);
        #1;
        check("t3_rdy0", req_ready, 3'b010);
        @(negedge clk);
        set_beat(1, 32'hBBBB_0001, 1'b1);
        #1;
        check("t3_err", req_err, 3'b010);
        check("t3_noload", key_load, 0);
        @(negedge clk);
        req_valid            = 3'b101;
        req_data[31:0]       = 32'hDEAD_0000;
        req_data[95:64]      = 32'hC0C0_0000;
        #1;
        check("t3_err_off", req_err, 0);
        check("t3_idle", busy, 0);
        @(negedge clk);
        #1;
        check("t3_gid", grant_id, 2);
        check("t3_rdy2", req_ready, 3'b100);

        // 4: tamper during beat 2 of req2
        @(negedge clk);
        set_beat(2, 32'hC0C0_0001, 1'b0);
        #1;
        check("t4_rdy1", req_ready, 3'b100);
        @(negedge clk);
        set_beat(2, 32'hC0C0_0002, 1'b0);
        tamper = 1'b1;
        #1;
        check("t4_rdy_wipe", req_ready, 0);
        zc    = 0;
        quiet = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear_req();
            tamper = 1'b0;
            #1;
            if (key_zeroize) zc++;
            if (req_done != 0 || req_err != 0 || key_load ||
                key_data != 0) quiet = 1'b1;
        end
        check("t4_zcycles", zc, 4);
        check("t4_quiet", quiet, 0);
        check("t4_idle", busy, 0);
        load_key(0, 32'hCAFE_0000, 32'h1, 1'b0, "t4_load");

        // 5: soft wipe in the commit cycle, retriggered at hold cycle 2
        load_key(1, 32'h5555_0000, 32'h10, 1'b1, "t5");
        zc = 0;
        zl = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            soft_zeroize = (i == 2);
            #1;
            if (key_zeroize) begin
                zc++;
                zl = i;
            end
        end
        soft_zeroize = 1'b0;
        check("t5_zcycles", zc, 6);
        check("t5_zlast", zl, 6);
        check("t5_idle", busy, 0);

`ifdef KEY_SEQ_LOCK_EN
        // 6: lock blocks loads until a wipe completes
        @(negedge clk);
        lock = 1'b1;
        #1;
        @(negedge clk);
        lock = 1'b0;
        set_beat(0, 32'h0000_0001, 1'b0);
        #1;
        check("t6_locked", locked, 1);
        check("t6_err", req_err, 3'b001);
        check("t6_rdy", req_ready, 0);
        @(negedge clk);
        #1;
        check("t6_err_once", req_err, 0);
        check("t6_rdy2", req_ready, 0);
        check("t6_nogrant", busy, 0);
        @(negedge clk);
        clear_req();
        soft_zeroize = 1'b1;
        @(negedge clk);
        soft_zeroize = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("t6_unlocked", locked, 0);
        check("t6_idle", busy, 0);
        load_key(0, 32'h7777_0000, 32'h1, 1'b0, "t6_load");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
